// File: rtl/ch0re_ifetch_if.sv
// ch0re_ifetch_if: instruction-memory, decoder and redirect signals of the fetch stage
interface ch0re_ifetch_if;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
  logic        o_exc_misaligned;
  logic        i_instr_ready;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  modport master (
    output o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_pc, o_exc_misaligned,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_instr_ready, i_redirect, i_redirect_pc
  );
  modport slave (
    input  o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_pc, o_exc_misaligned,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_instr_ready, i_redirect, i_redirect_pc
  );
endinterface

// File: rtl/ch0re_ifetch.sv
// ch0re_ifetch: fetch stage with PC, credit-limited imem requests, request-PC tag FIFO and decoder queue; CH0RE_IFETCH_BYPASS_EN enables same-cycle response bypass
module ch0re_ifetch #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  ch0re_ifetch_if.master bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(QUEUE_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_e;
  state_e state_q;
  logic [63:0] pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [CW:0] used;
  logic [AW-1:0] wr_q, rd_q, tw_q, tr_q;
  logic [31:0] qi_q [QUEUE_DEPTH];
  logic [63:0] qp_q [QUEUE_DEPTH];
  logic [63:0] tag_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] qe_q;
  logic redir, mis, gnt, rsp, keep, pop, push, byp;
  assign redir = bus.i_redirect;
  assign mis   = redir && bus.i_redirect_pc[1:0] != 2'b00;
  assign gnt   = bus.o_imem_req && bus.i_imem_gnt;
  assign rsp   = bus.i_imem_rvalid && outst_q != '0;
  assign keep  = rsp && disc_q == '0 && !redir;
  assign pop   = cnt_q != '0 && bus.i_instr_ready;
`ifdef CH0RE_IFETCH_BYPASS_EN
  assign byp   = keep && cnt_q == '0 && bus.i_instr_ready;
`else
  assign byp   = 1'b0;
`endif
  assign push  = keep && !byp;
  // the entry leaving this cycle frees its credit, which keeps 1 instr/cycle at depth 2
  assign used  = {1'b0, outst_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
  assign bus.o_imem_req       = state_q == FETCH && used < DEPTH;
  assign bus.o_imem_addr      = pc_q;
  assign bus.o_instr_valid    = cnt_q != '0 || byp;
  assign bus.o_instr          = byp ? bus.i_imem_rdata : qi_q[rd_q];
  assign bus.o_pc             = byp ? tag_q[tr_q] : qp_q[rd_q];
  assign bus.o_exc_misaligned = !byp && cnt_q != '0 && qe_q[rd_q];
  // next PC, credit, discard and occupancy; a redirect overrides everything
  always_comb begin
    pc_d    = redir ? bus.i_redirect_pc : gnt ? pc_q + 64'd4 : pc_q;
    outst_d = outst_q + CW'(gnt) - CW'(rsp);
    disc_d  = redir ? outst_d : disc_q - CW'(rsp && disc_q != '0);
    cnt_d   = redir ? CW'(mis) : cnt_q + CW'(push) - CW'(pop);
  end
  // FSM and control counters
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= redir ? (mis ? HALT : FETCH) : (state_q == IDLE ? FETCH : state_q);
      pc_q    <= pc_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
    end
  // tag FIFO of granted PCs and the decoder queue storage
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      tw_q <= '0;
      tr_q <= '0;
      qe_q <= '0;
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        qi_q[k]  <= '0;
        qp_q[k]  <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      if (gnt) begin
        tag_q[tw_q] <= pc_q;
        tw_q        <= tw_q + AW'(1);
      end
      if (rsp) tr_q <= tr_q + AW'(1);
      if (redir) begin
        rd_q <= '0;
        wr_q <= AW'(mis);
        if (mis) begin
          qi_q[0] <= '0;
          qp_q[0] <= bus.i_redirect_pc;
          qe_q[0] <= 1'b1;
        end
      end else begin
        if (push) begin
          qi_q[wr_q] <= bus.i_imem_rdata;
          qp_q[wr_q] <= tag_q[tr_q];
          qe_q[wr_q] <= 1'b0;
          wr_q       <= wr_q + AW'(1);
        end
        if (pop) rd_q <= rd_q + AW'(1);
      end
    end
endmodule
